slt_cmp_scheduler: RTL and testbench
====================================

Name: slt_cmp_scheduler

Overview:
- Shared, digit-serial signed less-than engine serving NREQ requesters through valid/ready handshakes.
- Round-robin arbitration selects one requester and latches its operand pair.
- Compares MSB digit first, one DIGIT-bit slice per cycle, and stops at the first unequal digit.
- Sits in front of the crypto comparator benchmarks; lets one narrow compare slice replace several full-width comparators.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 32, two's-complement operand width; WIDTH % DIGIT must be 0.
- DIGIT, 8, bits compared per cycle; NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  NREQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b, same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result consumer ready.
- rsp_lt  output  1  1 iff signed(a) < signed(b).
- rsp_id  output  max(1,$clog2(NREQ))  index of the requester that issued the result.
- busy  output  1  high in CMP or RESP.

Behaviour:
- Reset values: rsp_valid=0, rsp_lt=0, rsp_id=0, busy=0, state=IDLE, rr pointer=0, digit index=NDIG-1. Reset has priority over everything, including mid-CMP and mid-RESP; the in-flight request is dropped and no response is produced.
- States: IDLE, CMP, RESP.
- IDLE:
  - g = first i with req_valid[i]=1, searching from rr pointer upward with wrap.
  - req_ready[g]=1 combinationally; all other bits 0. No valid requests gives all 0.
  - On req_valid[g]&req_ready[g] (cycle t): latch a, b and g; set digit index=NDIG-1; rr pointer=(g+1) mod NREQ; go to CMP.
- CMP, one digit per cycle from index NDIG-1 down to 0:
  - Top digit (index NDIG-1) compares signed: its MSB is inverted on both operands, then the digits are compared unsigned. Lower digits compare unsigned.
  - If the digits differ: rsp_lt = (a digit < b digit); go to RESP.
  - If equal and index=0: rsp_lt=0; go to RESP.
  - Otherwise decrement index and stay in CMP.
- Latency: with k digits examined (1..NDIG), rsp_valid rises at cycle t+1+k.
- RESP:
  - rsp_valid=1; rsp_lt and rsp_id are held stable until rsp_valid&rsp_ready.
  - On the transfer, go to IDLE. No new request is accepted in the transfer cycle; the earliest next accept is the following cycle.
- req_ready is 0 in CMP and RESP. Operand inputs are ignored after the accept cycle.
- Requesters must hold req_valid and operands until accepted. Deasserting req_valid before acceptance is allowed and simply removes the request.
- No output depends combinationally on rsp_ready.

Optional Feature:
- Macro SLT_EARLY_EXIT_EN.
- Defined: CMP exits at the first unequal digit, as described above.
- Undefined (constant-time mode for side-channel-sensitive use):
  - All NDIG digits are always processed; the decision is captured at the first unequal digit and not overwritten.
  - rsp_valid always rises at t+1+NDIG.
  - Result values are identical in both modes.

Test Plan (WIDTH=32, DIGIT=8, NREQ=4):
- Reset, then idle with all req_valid=0 -> req_ready=0000, rsp_valid=0, busy=0 every cycle.
- Requester 2 only, a=0xFFFFFFFF, b=0x00000001, accepted at t -> rsp_lt=1, rsp_id=2. rsp_valid at t+2 with SLT_EARLY_EXIT_EN defined, t+5 without.
- a=0x12345678, b=0x12345679 -> rsp_lt=1 at t+5; a=0x7FFFFFFF, b=0x80000000 -> rsp_lt=0 at t+2 (early exit) / t+5.
- a=b=0x80000000 -> rsp_lt=0, rsp_valid at t+5 in both modes.
- All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0. Exactly one req_ready bit high in IDLE cycles only.
- rsp_ready held 0 for 3 cycles -> rsp_valid, rsp_lt, rsp_id stable and req_ready=0000. Separately, rst pulsed during CMP -> next cycle state IDLE, rsp_valid=0, next grant goes to requester 0.

Source files
------------

// File: rtl/slt_cmp_scheduler.sv
// ============================================================================
// Module   : slt_cmp_scheduler
// Summary  : Round-robin shared, digit-serial signed less-than engine.
//            Compares one DIGIT-bit slice per cycle, MSB digit first.
//            Macro SLT_EARLY_EXIT_EN: stop at first unequal digit; when left
//            undefined every digit is always processed (constant time).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slt_cmp_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int DIGIT = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_lt,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [DW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_lt_q, rsp_lt_d;
  logic             busy_q, busy_d;
`ifndef SLT_EARLY_EXIT_EN
  logic             dec_q, dec_d;
  logic             cmp_lt_q, cmp_lt_d;
`endif

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             dig_ne, dig_lt;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NREQ)) s = s - 32'(NREQ);
    return s[IDW-1:0];
  endfunction

  // First valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = wrap_add(rr_q, i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Inverting the sign bit of the top digit turns the signed compare unsigned.
  always_comb begin
    a_dig = a_q[idx_q*DIGIT +: DIGIT];
    b_dig = b_q[idx_q*DIGIT +: DIGIT];
    if (idx_q == DW'(NDIG-1)) begin
      a_dig[DIGIT-1] = ~a_dig[DIGIT-1];
      b_dig[DIGIT-1] = ~b_dig[DIGIT-1];
    end
    dig_ne = (a_dig != b_dig);
    dig_lt = (a_dig < b_dig);
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_lt_d    = rsp_lt_q;
    busy_d      = busy_q;
`ifndef SLT_EARLY_EXIT_EN
    dec_d       = dec_q;
    cmp_lt_d    = cmp_lt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          a_d     = req_a[grant_idx*WIDTH +: WIDTH];
          b_d     = req_b[grant_idx*WIDTH +: WIDTH];
          id_d    = grant_idx;
          idx_d   = DW'(NDIG-1);
          rr_d    = wrap_add(grant_idx, 1);
          busy_d  = 1'b1;
          state_d = S_CMP;
`ifndef SLT_EARLY_EXIT_EN
          dec_d    = 1'b0;
          cmp_lt_d = 1'b0;
`endif
        end
      end
      S_CMP: begin
`ifdef SLT_EARLY_EXIT_EN
        if (dig_ne || idx_q == '0) begin
          rsp_lt_d    = dig_ne & dig_lt;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          idx_d = idx_q - DW'(1);
        end
`else
        // Decision is frozen at the first unequal digit; the walk continues.
        if (!dec_q && dig_ne) begin
          dec_d    = 1'b1;
          cmp_lt_d = dig_lt;
        end
        if (idx_q == '0) begin
          rsp_lt_d    = dec_q ? cmp_lt_q : (dig_ne & dig_lt);
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          idx_d = idx_q - DW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      idx_q       <= DW'(NDIG-1);
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lt_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifndef SLT_EARLY_EXIT_EN
      dec_q       <= 1'b0;
      cmp_lt_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lt_q    <= rsp_lt_d;
      busy_q      <= busy_d;
`ifndef SLT_EARLY_EXIT_EN
      dec_q       <= dec_d;
      cmp_lt_q    <= cmp_lt_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_slt_cmp_scheduler.sv
// ============================================================================
// Module   : tb_slt_cmp_scheduler
// Summary  : Self-checking bench for slt_cmp_scheduler (honours SLT_EARLY_EXIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slt_cmp_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int NDIG  = WIDTH / DIGIT;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready, rsp_lt, busy;
  logic [1:0]            rsp_id;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  int checks   = 0;
  int failures = 0;
  int model_rr = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  end

  slt_cmp_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lt(rsp_lt), .rsp_id(rsp_id), .busy(busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: round-robin search from the model pointer.
  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[(model_rr + i) % NREQ]) return (model_rr + i) % NREQ;
    return -1;
  endfunction

  // Reference: digits examined = digits down to the highest differing bit.
  function automatic int exp_digits(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
`ifndef SLT_EARLY_EXIT_EN
    return NDIG;
`else
    x = a ^ b;
    for (int bt = WIDTH-1; bt >= 0; bt--)
      if (x[bt]) return NDIG - bt / DIGIT;
    return NDIG;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] mk_b(input logic [WIDTH-1:0] a);
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return a ^ (32'd1 << $urandom_range(0, 31));
      2:       return a;
      default: return a ^ ($urandom & 32'h0000_00FF);
    endcase
  endfunction

  // One full transaction from the current IDLE cycle to the cycle after transfer.
  task automatic serve(input int hold, input bit reissue);
    int g, k;
    logic [WIDTH-1:0] ea, eb;
    logic elt;
    #1;
    g = exp_grant(req_valid);
    if (g < 0) begin
      check("grant_exists", 32'(req_ready), 32'hFFFF_FFFF);
      return;
    end
    check("grant", 32'(req_ready), 32'(1) << g);
    ea = op_a[g];
    eb = op_b[g];
    k  = exp_digits(ea, eb);
    elt = ($signed(ea) < $signed(eb));
    model_rr = (g + 1) % NREQ;
    tick();
    if (reissue) begin
      op_a[g] = $urandom;
      op_b[g] = mk_b(op_a[g]);
    end else begin
      req_valid[g] = 1'b0;
    end
    for (int c = 1; c <= k; c++) begin
      #1;
      check("cmp_phase", {26'd0, busy, rsp_valid, req_ready}, {26'd0, 1'b1, 1'b0, 4'b0000});
      tick();
    end
    #1;
    check("rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    check("rsp_lt", {31'd0, rsp_lt}, {31'd0, elt});
    check("rsp_id", {30'd0, rsp_id}, 32'(g));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      tick();
      #1;
      check("resp_hold", {24'd0, rsp_valid, rsp_lt, rsp_id, req_ready},
            {24'd0, 1'b1, elt, 2'(g), 4'b0000});
    end
    rsp_ready = 1'b1;
    #1;
    check("xfer_no_accept", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    #1;
    check("after_xfer", {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset_state", {24'd0, rsp_valid, rsp_lt, rsp_id, busy, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("idle", {26'd0, req_ready, rsp_valid, busy}, 32'd0);
    end

    // Directed operand patterns from the test plan.
    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h0000_0001; req_valid = 4'b0100;
    serve(0, 1'b0);
    op_a[0] = 32'h1234_5678; op_b[0] = 32'h1234_5679; req_valid = 4'b0001;
    serve(0, 1'b0);
    op_a[1] = 32'h7FFF_FFFF; op_b[1] = 32'h8000_0000; req_valid = 4'b0010;
    serve(1, 1'b0);
    op_a[3] = 32'h8000_0000; op_b[3] = 32'h8000_0000; req_valid = 4'b1000;
    serve(3, 1'b0);

    // All requesters pending: pointer is back at 0, so order 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = $urandom;
      op_b[i] = mk_b(op_a[i]);
    end
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) serve(0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = $urandom;
        op_b[i] = mk_b(op_a[i]);
      end
      req_valid = 4'($urandom_range(1, 15));
      serve($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset mid-compare drops the request and clears the pointer.
    op_a[2] = 32'h0000_0005; op_b[2] = 32'h0000_0004; req_valid = 4'b0100;
    #1;
    check("pre_reset_grant", 32'(req_ready), 32'(1) << exp_grant(req_valid));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    model_rr = 0;
    #1;
    check("post_reset_idle", {30'd0, busy, rsp_valid}, 32'd0);
    serve(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
